regfile_dump_rx: RTL and testbench
==================================

// Module: regfile_dump_rx
// PURPOSE
// - Host/bench-side receiver for the 128-byte register-file dump the narvie core emits over UART after each executed instruction.
// - Consumes bytes from a uart_rx byte receiver and reassembles them into 32 x 32-bit register words.
// - Emits one word-write per register, then a done pulse; detects truncated dumps by inter-byte timeout.
// PARAMETERS
// - TIMEOUT_CYC, default 20000: idle clk12 cycles allowed between bytes inside a dump (~1.7 ms at 12 MHz).
// - DUMP_BYTES, default 128: bytes per dump (32 regs x 4); fixed by the wire format, not for tuning.
// PORTS
// - clk12        in   1   single system clock (12 MHz)
// - rstn         in   1   asynchronous active-low reset
// - rx_data      in   8   received byte from uart_rx
// - rx_valid     in   1   1-cycle strobe: rx_data valid
// - reg_we       out  1   1-cycle strobe: reg_addr/reg_data valid
// - reg_addr     out  5   register index of reassembled word
// - reg_data     out  32  reassembled register value
// - dump_done    out  1   1-cycle pulse: all 32 words emitted
// - dump_err     out  1   1-cycle pulse: dump aborted by timeout
// - busy         out  1   high while a dump is in progress
// - rd_addr      in   5   shadow read address (REGDUMP_SHADOW_EN)
// - rd_data      out  32  shadow read data, registered, 1-cycle latency
// BEHAVIOUR
// - Wire format: stream byte n (0..127) carries reg r=((n+1)>>2)&31, lane l=(n+1)&3; lane map 0:[31:24] 1:[7:0] 2:[15:8] 3:[23:16].
//   Hence reg k>=1: MSB at byte 4k-1, low bytes at 4k..4k+2; reg 0: low bytes at 0..2, MSB at byte 127 (last).
// - Reset: all outputs 0, state IDLE, byte counter 0, staging regs 0, rd_data 0.
// - States: IDLE -> RECV on first rx_valid (that byte is n=0); RECV -> FLUSH after byte 127; FLUSH -> IDLE after emitting reg 0.
// - RECV: 7-bit counter cnt = n; each rx_valid stores byte into its lane of the staging word, then cnt++.
//   - byte n with (n&3)==2, n<126: reg_we next cycle, reg_addr=n>>2, reg_data={msb_hold,b2,b1,b0}; for reg 0 the three low bytes are instead saved in r0_low.
//   - byte n with (n&3)==3: msb_hold <= byte (MSB of reg (n+1)>>2).
//   - byte 126 completes reg 31 ({msb_hold from byte 123,...}); byte 127 is reg 0 MSB -> FLUSH.
// - FLUSH: one cycle, reg_we=1, reg_addr=0, reg_data={byte127,r0_low}; dump_done pulses in the same cycle; busy drops next cycle.
// - Order of writes: regs 1..31 then 0; exactly 32 reg_we strobes per good dump; reg_we latency = 1 cycle after the completing rx_valid.
// - Timeout: idle counter cleared on every rx_valid, counts in RECV; reaching TIMEOUT_CYC -> dump_err pulse, state IDLE, cnt 0, no dump_done; partial writes already emitted stand.
// - rx_valid on consecutive cycles is legal; rx_valid during FLUSH is taken as byte 0 of the next dump (FLUSH still completes).
// - busy = (state != IDLE). reg 0 value is passed through unchecked (nonzero reg 0 is a bench-visible core bug).
// - Reset mid-dump: immediate return to IDLE, no pulses, staging discarded.
// CONFIGURATION
// - REGDUMP_SHADOW_EN defined: internal 32x32 shadow array written by every reg_we; rd_data <= shadow[rd_addr] each clk12; shadow resets to 0.
// - REGDUMP_SHADOW_EN undefined: no array; rd_data constant 0; rd_addr ignored.
// STRUCTURE
// - Shared header: DUMP_BYTES=128, NUM_REGS=32, lane-map constants LANE_MSB/LANE_B0/LANE_B1/LANE_B2, state encodings.
// - One sub-module: regdump_shadow_ram (32x32, 1 write + 1 registered read port), instantiated only under REGDUMP_SHADOW_EN.
// - Lane assembly, counter, timeout and FSM stay in this module.
// TESTING
// - Full dump, reg k = 32'hA0000000|k*32'h01010101 (reg0=0), bytes back-to-back -> 32 writes, regs 1..31 then 0, exact values, one dump_done.
// - Same dump with 10k idle cycles between bytes (TIMEOUT_CYC=20000) -> identical writes, no dump_err.
// - Stop after byte 57 -> regs 1..13 written, dump_err once after TIMEOUT_CYC idle cycles, busy=0, no dump_done; next full dump correct.
// - reg0 MSB byte 127 = 8'h5A -> final write addr 0 data 32'h5A000000|r0_low.
// - rstn low after byte 40, then full dump -> no pulses during reset; subsequent dump produces exactly 32 correct writes.
// - REGDUMP_SHADOW_EN: after dump, rd_addr=7 -> rd_data=32'hA7070707 one cycle later; undefined -> rd_data stays 0.

Source files
------------

// File: rtl/regfile_dump_rx_pkg.sv
// ---------------------------------------------------------------------------
// regfile_dump_rx_pkg
// Shared definitions for the register-file dump receiver.
//   - Wire-format constants (bytes per dump, register count).
//   - Byte-lane codes. Stream byte n lands in lane (n+1)&3 of its register:
//     lane 0 = [31:24], lane 1 = [7:0], lane 2 = [15:8], lane 3 = [23:16].
//   - Receiver FSM state encoding.
// ---------------------------------------------------------------------------
package regfile_dump_rx_pkg;

    localparam int DUMP_BYTES = 128;
    localparam int NUM_REGS   = 32;

    localparam logic [1:0] LANE_MSB = 2'd0;
    localparam logic [1:0] LANE_B0  = 2'd1;
    localparam logic [1:0] LANE_B1  = 2'd2;
    localparam logic [1:0] LANE_B2  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Lane carried by stream byte n.
    function automatic logic [1:0] byte_lane(input logic [6:0] n);
        logic [6:0] n_plus;
        n_plus = n + 7'd1;
        return n_plus[1:0];
    endfunction

endpackage

// File: rtl/regdump_shadow_ram.sv
// ---------------------------------------------------------------------------
// regdump_shadow_ram
// 32 x 32-bit shadow copy of the most recently received register values.
// One write port, one registered read port (1-cycle latency).
// Contents clear to zero on reset.
// Ports:
//   clk12    in   system clock
//   rstn     in   asynchronous active-low reset
//   we       in   write strobe
//   wr_addr  in   write register index
//   wr_data  in   write value
//   rd_addr  in   read register index
//   rd_data  out  registered read value
// ---------------------------------------------------------------------------
module regdump_shadow_ram
    import regfile_dump_rx_pkg::*;
(
    input  logic        clk12,
    input  logic        rstn,
    input  logic        we,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [4:0]  rd_addr,
    output logic [31:0] rd_data
);

    logic [31:0] mem [NUM_REGS];

    always_ff @(posedge clk12 or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (we) begin
                mem[wr_addr] <= wr_data;
            end
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/regfile_dump_rx.sv
// ---------------------------------------------------------------------------
// regfile_dump_rx
// Receives the 128-byte register-file dump sent over UART after every
// executed instruction and reassembles it into 32 register writes
// (regs 1..31 in stream order, then reg 0, whose MSB is the last byte).
// A dump that stalls for TIMEOUT_CYC idle cycles is abandoned with dump_err.
// Optional feature macro: REGDUMP_SHADOW_EN adds a readable shadow copy of
// the received registers; without it rd_data is constant 0.
// Parameters:
//   TIMEOUT_CYC  idle cycles allowed between bytes inside a dump
//   DUMP_BYTES   bytes per dump (wire format, leave at 128)
// Ports:
//   clk12      in   system clock
//   rstn       in   asynchronous active-low reset
//   rx_data    in   received byte
//   rx_valid   in   1-cycle strobe, rx_data valid
//   reg_we     out  1-cycle strobe, reg_addr/reg_data valid
//   reg_addr   out  register index of reassembled word
//   reg_data   out  reassembled register value
//   dump_done  out  1-cycle pulse, all 32 words emitted
//   dump_err   out  1-cycle pulse, dump aborted by timeout
//   busy       out  high while a dump is in progress
//   rd_addr    in   shadow read address
//   rd_data    out  shadow read data, 1-cycle latency
// ---------------------------------------------------------------------------
module regfile_dump_rx #(
    parameter int TIMEOUT_CYC = 20000,
    parameter int DUMP_BYTES  = 128
) (
    input  logic        clk12,
    input  logic        rstn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        reg_we,
    output logic [4:0]  reg_addr,
    output logic [31:0] reg_data,
    output logic        dump_done,
    output logic        dump_err,
    output logic        busy,
    input  logic [4:0]  rd_addr,
    output logic [31:0] rd_data
);

    import regfile_dump_rx_pkg::*;

    localparam int             IDLE_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
    localparam logic [6:0]     LAST_N    = 7'(DUMP_BYTES - 1);
    localparam logic [6:0]     R0_DONE_N = 7'd2;

    state_t            state;
    logic [6:0]        cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [7:0]        b0;
    logic [7:0]        b1;
    logic [7:0]        msb_hold;
    logic [23:0]       r0_low;

    // Index of the byte arriving now: a byte seen outside RECV always starts
    // a new dump, including one that lands in the FLUSH cycle.
    logic [6:0]        cur_n;
    logic [1:0]        cur_lane;

    always_comb begin
        cur_n    = (state == ST_RECV) ? cnt : 7'd0;
        cur_lane = byte_lane(cur_n);
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk12 or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            idle_cnt  <= '0;
            b0        <= '0;
            b1        <= '0;
            msb_hold  <= '0;
            r0_low    <= '0;
            reg_we    <= 1'b0;
            reg_addr  <= '0;
            reg_data  <= '0;
            dump_done <= 1'b0;
            dump_err  <= 1'b0;
        end else begin
            reg_we    <= 1'b0;
            dump_done <= 1'b0;
            dump_err  <= 1'b0;

            if (rx_valid) begin
                idle_cnt <= '0;
                cnt      <= cur_n + 7'd1;
                state    <= (cur_n == LAST_N) ? ST_FLUSH : ST_RECV;

                case (cur_lane)
                    LANE_B0: b0 <= rx_data;
                    LANE_B1: b1 <= rx_data;
                    LANE_B2: begin
                        // Third low byte completes a word. Reg 0's MSB only
                        // arrives at the very end, so park its low bytes.
                        if (cur_n == R0_DONE_N) begin
                            r0_low <= {rx_data, b1, b0};
                        end else begin
                            reg_we   <= 1'b1;
                            reg_addr <= cur_n[6:2];
                            reg_data <= {msb_hold, rx_data, b1, b0};
                        end
                    end
                    default: begin // LANE_MSB
                        if (cur_n == LAST_N) begin
                            // Reg 0 write and done share the FLUSH cycle.
                            reg_we    <= 1'b1;
                            reg_addr  <= 5'd0;
                            reg_data  <= {rx_data, r0_low};
                            dump_done <= 1'b1;
                            cnt       <= '0;
                        end else begin
                            msb_hold <= rx_data;
                        end
                    end
                endcase
            end else begin
                case (state)
                    ST_RECV: begin
                        if (idle_cnt == IDLE_LAST) begin
                            dump_err <= 1'b1;
                            state    <= ST_IDLE;
                            cnt      <= '0;
                            idle_cnt <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + IDLE_W'(1);
                        end
                    end
                    ST_FLUSH: state <= ST_IDLE;
                    default:  state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef REGDUMP_SHADOW_EN
    regdump_shadow_ram u_shadow (
        .clk12   (clk12),
        .rstn    (rstn),
        .we      (reg_we),
        .wr_addr (reg_addr),
        .wr_data (reg_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^rd_addr;
    assign rd_data        = '0;
`endif

endmodule

// File: tb/tb_regfile_dump_rx.sv
// ---------------------------------------------------------------------------
// tb_regfile_dump_rx
// Drives directed dumps into regfile_dump_rx. Expected register writes are
// queued when a dump is issued; a monitor pops and compares on every reg_we.
// The DUT timeout is shortened so idle-gap and timeout cases stay short;
// gaps keep the same proportion to the timeout (half of it, and just under).
// ---------------------------------------------------------------------------
module tb_regfile_dump_rx;

    localparam int T = 200;

    logic        clk12 = 1'b0;
    logic        rstn  = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        reg_we;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic        dump_done;
    logic        dump_err;
    logic        busy;
    logic [4:0]  rd_addr = '0;
    logic [31:0] rd_data;

    regfile_dump_rx #(.TIMEOUT_CYC(T), .DUMP_BYTES(128)) dut (
        .clk12     (clk12),
        .rstn      (rstn),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_data  (reg_data),
        .dump_done (dump_done),
        .dump_err  (dump_err),
        .busy      (busy),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    always #5 clk12 = ~clk12;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int err_cyc = 0;
    int last_cyc = 0;

    always @(posedge clk12) cyc++;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [31:0] regs [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk12) begin
        if (rstn) begin
            if (reg_we) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: addr %0d data %h, no write expected", reg_addr, reg_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk($sformatf("write_addr(r%0d)", mon_e.a), {27'd0, reg_addr}, {27'd0, mon_e.a});
                    chk($sformatf("write_data(r%0d)", mon_e.a), reg_data, mon_e.d);
                end
            end
            if (dump_done) begin
                done_cnt++;
                chk("done_with_reg0_write", {31'd0, reg_we && (reg_addr == 5'd0)}, 32'd1);
            end
            if (dump_err) begin
                err_cnt++;
                err_cyc = cyc;
            end
        end
    end

    // Byte n of the dump built from regs[].
    function automatic logic [7:0] wire_byte(input int n);
        int r;
        int l;
        logic [31:0] v;
        r = ((n + 1) >> 2) & 31;
        l = (n + 1) & 3;
        v = regs[r];
        case (l)
            0:       return v[31:24];
            1:       return v[7:0];
            2:       return v[15:8];
            default: return v[23:16];
        endcase
    endfunction

    task automatic set_pattern(input logic [31:0] r0);
        for (int k = 1; k < 32; k++) regs[k] = 32'hA0000000 | (k * 32'h01010101);
        regs[0] = r0;
    endtask

    task automatic push_regs(input int lo, input int hi, input bit with_r0);
        for (int k = lo; k <= hi; k++) exp_q.push_back({5'(k), regs[k]});
        if (with_r0) exp_q.push_back({5'd0, regs[0]});
    endtask

    // Called aligned 1 time unit after a rising edge; returns likewise.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk12);
        #1;
        last_cyc = cyc;
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk12);
            #1;
        end
    endtask

    task automatic send_dump(input int first, input int last, input int gap, input int slow_n);
        for (int n = first; n <= last; n++) begin
            send_byte(wire_byte(n), (n == slow_n) ? (T - 2) : gap);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            @(posedge clk12);
            #1;
        end
        chk({name, "_pending_writes"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk12);
            #1;
        end
    endtask

    initial begin
        // Reset state.
        tick(3);
        chk("reset_ctrl", {28'd0, reg_we, dump_done, dump_err, busy}, 32'd0);
        chk("reset_addr", {27'd0, reg_addr}, 32'd0);
        chk("reset_data", reg_data, 32'd0);
        chk("reset_rd_data", rd_data, 32'd0);
        rstn = 1'b1;
        tick(2);

        // 1: full dump, back-to-back bytes.
        set_pattern(32'd0);
        push_regs(1, 31, 1'b1);
        done_cnt = 0; err_cnt = 0;
        send_byte(wire_byte(0), 0);
        chk("busy_after_byte0", {31'd0, busy}, 32'd1);
        send_dump(1, 127, 0, -1);
        tick(3);
        drain("fast_dump");
        chk("fast_done_count", done_cnt, 1);
        chk("fast_err_count", err_cnt, 0);
        chk("fast_busy_after", {31'd0, busy}, 32'd0);
        rd_addr = 5'd7;
        tick(1);
`ifdef REGDUMP_SHADOW_EN
        chk("shadow_r7", rd_data, 32'hA7070707);
`else
        chk("shadow_off_r7", rd_data, 32'd0);
`endif

        // 2: same dump with long idle gaps, one just under the timeout.
        push_regs(1, 31, 1'b1);
        done_cnt = 0; err_cnt = 0;
        send_dump(0, 127, T / 2, 64);
        tick(3);
        drain("slow_dump");
        chk("slow_done_count", done_cnt, 1);
        chk("slow_err_count", err_cnt, 0);

        // 3: truncated after byte 57 -> regs 1..13 then timeout.
        push_regs(1, 13, 1'b0);
        done_cnt = 0; err_cnt = 0;
        send_dump(0, 57, 0, -1);
        for (int i = 0; i < T + 20 && err_cnt == 0; i++) tick(1);
        tick(2);
        drain("trunc_dump");
        chk("trunc_err_count", err_cnt, 1);
        chk("trunc_err_delay_ok", {31'd0, (err_cyc - last_cyc >= T - 1) && (err_cyc - last_cyc <= T + 1)}, 32'd1);
        chk("trunc_done_count", done_cnt, 0);
        chk("trunc_busy_after", {31'd0, busy}, 32'd0);

        push_regs(1, 31, 1'b1);
        done_cnt = 0; err_cnt = 0;
        send_dump(0, 127, 0, -1);
        tick(3);
        drain("post_trunc_dump");
        chk("post_trunc_done_count", done_cnt, 1);
        chk("post_trunc_err_count", err_cnt, 0);

        // 4: reset after byte 40, outputs quiet during reset.
        push_regs(1, 9, 1'b0);
        send_dump(0, 40, 0, -1);
        tick(2);
        drain("pre_reset_partial");
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("in_reset_quiet", {28'd0, reg_we, dump_done, dump_err, busy}, 32'd0);
        end
        rstn = 1'b1;
        tick(2);

        // 5: full dump, then a second dump whose byte 0 lands in the FLUSH
        //    cycle of the first; the second carries reg 0 MSB = 8'h5A.
        done_cnt = 0; err_cnt = 0;
        push_regs(1, 31, 1'b1);
        send_dump(0, 127, 0, -1);
        set_pattern(32'h5AC3B2A1);
        push_regs(1, 31, 1'b1);
        send_dump(0, 127, 0, -1);
        tick(3);
        drain("overlap_dumps");
        chk("overlap_done_count", done_cnt, 2);
        chk("overlap_err_count", err_cnt, 0);
        rd_addr = 5'd0;
        tick(1);
`ifdef REGDUMP_SHADOW_EN
        chk("shadow_r0", rd_data, 32'h5AC3B2A1);
`else
        chk("shadow_off_r0", rd_data, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
